des_iter_core: RTL

- Iterative DES block cipher core: one Feistel round per clock, 16 rounds per 64-bit block.
- Supports both encryption and decryption. The direction is selected per block through the key-schedule rotation direction.
- Consumes the 6-to-4 S-box substitution stage (S1..S8) in the round function f.
- Sits between the host-facing block buffer and the output FIFO, with valid/ready handshakes on both sides.

---
 rtl/des_iter_core_if.sv | 23 ++
 rtl/des_iter_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_iter_core_if.sv
// Handshake bundle between the host block buffer, the DES core and the output FIFO.
// Signal names follow the core's point of view (_i into the core, _o out of it).
interface des_iter_core_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        decrypt_i;
    logic [63:0] key_i;
    logic [63:0] data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] data_o;
    logic        busy_o;

    modport master (
        output in_valid_i, decrypt_i, key_i, data_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, busy_o
    );

    modport slave (
        input  in_valid_i, decrypt_i, key_i, data_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, busy_o
    );
endinterface

// File: rtl/des_iter_core.sv
// Iterative DES core: one Feistel round per clock, 16 rounds per block, encrypt or decrypt
// selected per block by the key-schedule rotation direction.
module des_iter_core #(
    parameter int unsigned NUM_ROUNDS = 16
) (
    input logic            clk,
    input logic            rst_n,
    des_iter_core_if.slave bus
);

    if (NUM_ROUNDS != 16) begin : gen_rounds_check
        $error("des_iter_core: NUM_ROUNDS must be 16");
    end

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    // Tables use FIPS 46-3 numbering: entry n selects input bit n, bit 1 being the MSB.
    localparam int unsigned IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int unsigned FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int unsigned E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int unsigned P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // S1..S8, each 4 rows x 16 columns, row-major.
    localparam logic [3:0] SBOX [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_TAB[i]];
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_TAB[i]];
        return o;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_TAB[i]];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_TAB[i]];
        return o;
    endfunction

    function automatic logic [47:0] expand(input logic [31:0] x);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = x[32-E_TAB[i]];
        return o;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[31-i] = x[32-P_TAB[i]];
        return o;
    endfunction

    // Group i (MSB first) feeds S(i+1); row = {b5,b0}, column = b4..b1.
    function automatic logic [31:0] sbox_sub(input logic [47:0] x);
        logic [31:0] o;
        logic [5:0]  g;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            g = x[47-6*i -: 6];
            o[31-4*i -: 4] = SBOX[64*i + int'({g[5], g[0], g[4:1]})];
        end
        return o;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n,
                                          input logic right);
        logic [27:0] o;
        o = x;
        if (right) begin
            if (n == 2'd1)      o = {x[0], x[27:1]};
            else if (n == 2'd2) o = {x[1:0], x[27:2]};
        end else begin
            if (n == 2'd1)      o = {x[26:0], x[27]};
            else if (n == 2'd2) o = {x[25:0], x[27:26]};
        end
        return o;
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  round_q, round_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        mode_q, mode_d;
    logic [63:0] data_q, data_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;

    logic [1:0]  shamt;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey;
    logic [31:0] r_new;

    // Decrypt walks the schedule backwards; round 1 uses the unrotated PC1 halves (K16).
    always_comb begin
        shamt = 2'd2;
        if (mode_q) begin
            if (round_q == 5'd1) shamt = 2'd0;
            else if (round_q inside {5'd2, 5'd9, 5'd16}) shamt = 2'd1;
        end else if (round_q inside {5'd1, 5'd2, 5'd9, 5'd16}) begin
            shamt = 2'd1;
        end
        c_rot  = rot28(c_q, shamt, mode_q);
        d_rot  = rot28(d_q, shamt, mode_q);
        subkey = perm_pc2({c_rot, d_rot});
        r_new  = l_q ^ perm_p(sbox_sub(expand(r_q) ^ subkey));
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        d_d         = d_q;
        mode_d      = mode_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid_i) begin
                    {l_d, r_d} = perm_ip(bus.data_i);
                    {c_d, d_d} = perm_pc1(bus.key_i);
                    mode_d     = bus.decrypt_i;
                    round_d    = 5'd1;
                    busy_d     = 1'b1;
                    state_d    = StRound;
                end
            end
            StRound: begin
                l_d = r_q;
                r_d = r_new;
                c_d = c_rot;
                d_d = d_rot;
                if (round_q == 5'(NUM_ROUNDS)) begin
                    // Output is FP of the swapped halves {R16, L16}.
                    data_d      = perm_fp({r_new, r_q});
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    round_d     = 5'd0;
                    state_d     = StDone;
                end else begin
                    round_d = round_q + 5'd1;
                end
            end
            StDone: begin
                if (bus.out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            round_q     <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            mode_q      <= 1'b0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            d_q         <= d_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready_o  = (state_q == StIdle);
    assign bus.out_valid_o = out_valid_q;
    assign bus.data_o      = data_q;
    assign bus.busy_o      = busy_q;

endmodule
